reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arbiter.sv | 112 +++++++++++
 tb/tb_reg_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_arbiter.sv
// Two-port round-robin arbiter for a shared register, with lockable ownership
// and an idle timeout that releases a lock the owner stops using.
module reg_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_lock,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_lock,
    output logic             req1_ready,
    output logic             reg_load,
    output logic [WIDTH-1:0] reg_in,
    output logic [1:0]       owner,
    output logic             last_grant
);

    localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state, state_nx;
    logic          prio, prio_nx;
    logic [CW-1:0] idle_cnt, idle_cnt_nx;
    logic          timed_out;
    logic          gnt0, gnt1;

    assign timed_out  = (idle_cnt == CW'(TIMEOUT));
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // In the expiry cycle the owner is no longer granted, so a late request
    // cannot re-arm a lock that is being released on this edge.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_nx    = state;
        prio_nx     = prio;
        idle_cnt_nx = idle_cnt;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        gnt0 = !prio;
                        gnt1 = prio;
                    end else begin
                        gnt0 = req0_valid;
                        gnt1 = req1_valid;
                    end
                end
                OWN0:    gnt0 = req0_valid && !timed_out;
                OWN1:    gnt1 = req1_valid && !timed_out;
                default: ;
            endcase
        end
        if (gnt0) begin
            prio_nx     = 1'b1;
            idle_cnt_nx = '0;
            state_nx    = req0_lock ? OWN0 : IDLE;
        end else if (gnt1) begin
            prio_nx     = 1'b0;
            idle_cnt_nx = '0;
            state_nx    = req1_lock ? OWN1 : IDLE;
        end else if (state != IDLE) begin
            if (timed_out) begin
                state_nx    = IDLE;
                idle_cnt_nx = '0;
                prio_nx     = (state == OWN0);
            end else begin
                idle_cnt_nx = idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            idle_cnt   <= '0;
            reg_load   <= 1'b0;
            reg_in     <= '0;
            last_grant <= 1'b0;
        end else begin
            state    <= state_nx;
            prio     <= prio_nx;
            idle_cnt <= idle_cnt_nx;
            reg_load <= gnt0 | gnt1;
            if (gnt0) begin
                reg_in     <= req0_data;
                last_grant <= 1'b0;
            end else if (gnt1) begin
                reg_in     <= req1_data;
                last_grant <= 1'b1;
            end
        end
    end

    always_comb begin
        owner = 2'b00;
        case (state)
            OWN0:    owner = 2'b01;
            OWN1:    owner = 2'b10;
            default: owner = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: directed scenarios plus random traffic
// against a transaction-level model of grants, locks and the idle timeout.
module tb_reg_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_lock = 1'b0, req1_valid = 1'b0, req1_lock = 1'b0;
    logic [15:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready, reg_load, last_grant;
    logic [15:0] reg_in;
    logic [1:0]  owner;

    int n_vec = 0;
    int n_err = 0;

    // Model: m_own is the lock holder (-1 none), m_gnt the port granted this cycle.
    int          m_own = -1, m_idle = 0, m_gnt = -1;
    bit          m_prio = 1'b0, m_load = 1'b0, m_last = 1'b0;
    logic [15:0] m_in = '0;

    reg_arbiter #(.WIDTH(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_lock(req0_lock), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_lock(req1_lock), .req1_ready(req1_ready),
        .reg_load(reg_load), .reg_in(reg_in), .owner(owner), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_owner();
        return (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
    endfunction

    task automatic apply(input bit r, input bit v0, input logic [15:0] d0, input bit l0,
                         input bit v1, input logic [15:0] d1, input bit l1);
        rst = r;
        req0_valid = v0; req0_data = d0; req0_lock = l0;
        req1_valid = v1; req1_data = d1; req1_lock = l1;
        m_gnt = -1;
        if (!r) begin
            if (m_own < 0) begin
                if (v0 && v1)  m_gnt = int'(m_prio);
                else if (v0)   m_gnt = 0;
                else if (v1)   m_gnt = 1;
            end else if (m_idle < TO) begin
                if ((m_own == 0) ? v0 : v1) m_gnt = m_own;
            end
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_own = -1; m_idle = 0; m_prio = 1'b0; m_load = 1'b0; m_in = '0; m_last = 1'b0;
        end else if (m_gnt >= 0) begin
            m_load = 1'b1;
            m_in   = (m_gnt == 0) ? req0_data : req1_data;
            m_last = (m_gnt == 1);
            m_prio = (m_gnt == 0);
            m_idle = 0;
            m_own  = ((m_gnt == 0) ? req0_lock : req1_lock) ? m_gnt : -1;
        end else begin
            m_load = 1'b0;
            if (m_own >= 0) begin
                if (m_idle >= TO) begin
                    m_prio = (m_own == 0);
                    m_own  = -1;
                    m_idle = 0;
                end else begin
                    m_idle++;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 1, 16'h1234, 1, 1, 16'h5678, 1);
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready0 got %b want 0", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready1 got %b want 0", req1_ready); end
        tick();
        n_vec++; if (reg_load !== 1'b0) begin n_err++; $display("FAIL rst_load got %b want 0", reg_load); end
        n_vec++; if (reg_in !== 16'h0000) begin n_err++; $display("FAIL rst_in got %h want 0000", reg_in); end
        n_vec++; if (owner !== 2'b00) begin n_err++; $display("FAIL rst_owner got %b want 00", owner); end
        n_vec++; if (last_grant !== 1'b0) begin n_err++; $display("FAIL rst_last got %b want 0", last_grant); end
    endtask

    task automatic test_round_robin();
        logic [15:0] want [2];
        want[0] = 16'h1111; want[1] = 16'h2222;
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 16'h1111, 0, 1, 16'h2222, 0);
            n_vec++; if (req0_ready !== (i == 0)) begin n_err++; $display("FAIL rr_ready0[%0d] got %b want %b", i, req0_ready, i == 0); end
            n_vec++; if (req1_ready !== (i == 1)) begin n_err++; $display("FAIL rr_ready1[%0d] got %b want %b", i, req1_ready, i == 1); end
            tick();
            n_vec++; if (reg_load !== 1'b1 || reg_in !== want[i]) begin
                n_err++; $display("FAIL rr_out[%0d] got load=%b in=%h want load=1 in=%h", i, reg_load, reg_in, want[i]);
            end
            n_vec++; if (last_grant !== 1'(i)) begin n_err++; $display("FAIL rr_last[%0d] got %b want %0d", i, last_grant, i); end
        end
    endtask

    task automatic test_lock();
        apply(0, 0, 16'h0, 0, 1, 16'hABCD, 1);
        tick();
        n_vec++; if (owner !== 2'b10 || reg_in !== 16'hABCD) begin
            n_err++; $display("FAIL lock_take got owner=%b in=%h want owner=10 in=abcd", owner, reg_in);
        end
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 16'h0F0F, 0, 0, 16'h0, 0);
            n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL lock_block[%0d] got %b want 0", i, req0_ready); end
            tick();
            n_vec++; if (owner !== 2'b10) begin n_err++; $display("FAIL lock_hold[%0d] got %b want 10", i, owner); end
        end
        apply(0, 1, 16'h0F0F, 0, 1, 16'h7777, 0);
        n_vec++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            n_err++; $display("FAIL lock_release got r0=%b r1=%b want r0=0 r1=1", req0_ready, req1_ready);
        end
        tick();
        n_vec++; if (owner !== 2'b00 || reg_in !== 16'h7777) begin
            n_err++; $display("FAIL lock_drop got owner=%b in=%h want owner=00 in=7777", owner, reg_in);
        end
        apply(0, 1, 16'h0F0F, 0, 0, 16'h0, 0);
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL lock_next got %b want 1", req0_ready); end
        tick();
    endtask

    task automatic test_timeout();
        int released = -1;
        apply(0, 1, 16'h4444, 1, 0, 16'h0, 0);
        tick();
        n_vec++; if (owner !== 2'b01) begin n_err++; $display("FAIL to_take got %b want 01", owner); end
        for (int i = 0; i < TO + 4 && released < 0; i++) begin
            apply(0, 0, 16'h0, 0, 1, 16'h3333, 0);
            n_vec++; if (req1_ready !== (m_gnt == 1)) begin n_err++; $display("FAIL to_ready1[%0d] got %b want %b", i, req1_ready, m_gnt == 1); end
            tick();
            n_vec++; if (owner !== exp_owner()) begin n_err++; $display("FAIL to_owner[%0d] got %b want %b", i, owner, exp_owner()); end
            if (owner === 2'b00) released = i;
        end
        n_vec++; if (released != TO) begin n_err++; $display("FAIL to_release got cycle %0d want %0d", released, TO); end
        apply(0, 0, 16'h0, 0, 1, 16'h3333, 0);
        n_vec++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL to_after got %b want 1", req1_ready); end
        tick();
        n_vec++; if (reg_in !== 16'h3333 || last_grant !== 1'b1) begin
            n_err++; $display("FAIL to_xfer got in=%h last=%b want in=3333 last=1", reg_in, last_grant);
        end
    endtask

    task automatic test_reset_mid_lock();
        apply(0, 1, 16'h5A5A, 1, 0, 16'h0, 0);
        tick();
        apply(1, 1, 16'hDEAD, 1, 0, 16'h0, 0);
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL rml_ready got %b want 0", req0_ready); end
        tick();
        n_vec++; if (reg_load !== 1'b0 || reg_in !== 16'h0000 || owner !== 2'b00) begin
            n_err++; $display("FAIL rml_state got load=%b in=%h owner=%b want 0/0000/00", reg_load, reg_in, owner);
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 16'hDEAD, 0, 0, 16'h0, 0);
            tick();
            n_vec++; if (reg_in === 16'hDEAD) begin n_err++; $display("FAIL rml_leak[%0d] got %h want not dead", i, reg_in); end
        end
    endtask

    task automatic test_back_to_back();
        int loads = 0;
        logic [15:0] d;
        for (int i = 0; i < 8; i++) begin
            d = 16'($urandom);
            apply(0, 0, 16'h0, 0, 1, d, 0);
            tick();
            if (reg_load === 1'b1) loads++;
            n_vec++; if (reg_in !== d) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, reg_in, d); end
        end
        n_vec++; if (loads != 8) begin n_err++; $display("FAIL b2b_loads got %0d want 8", loads); end
        apply(0, 0, 16'h0, 0, 0, 16'h0, 0);
        tick();
        n_vec++; if (reg_load !== 1'b0 || reg_in !== m_in) begin
            n_err++; $display("FAIL b2b_hold got load=%b in=%h want load=0 in=%h", reg_load, reg_in, m_in);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 49) == 0), $urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 3) == 0);
            n_vec++; if (req0_ready !== (m_gnt == 0) || req1_ready !== (m_gnt == 1)) begin
                n_err++; $display("FAIL rnd_ready[%0d] got %b%b want %b%b", i, req1_ready, req0_ready, m_gnt == 1, m_gnt == 0);
            end
            tick();
            n_vec++; if (reg_load !== m_load || reg_in !== m_in) begin
                n_err++; $display("FAIL rnd_reg[%0d] got load=%b in=%h want load=%b in=%h", i, reg_load, reg_in, m_load, m_in);
            end
            n_vec++; if (owner !== exp_owner() || last_grant !== m_last) begin
                n_err++; $display("FAIL rnd_state[%0d] got owner=%b last=%b want owner=%b last=%b", i, owner, last_grant, exp_owner(), m_last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid_lock();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
